// File: rtl/dem_min_norm_ctrl.sv
// DEM element-state controller: accumulates 18 4-bit usage states, scans for the
// minimum with one shared comparator, then renormalises. Optional: DEM_SAT_EN (saturating increment).
module dem_min_norm_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [17:0] in_sel,
    output logic [71:0] state_flat,
    output logic [3:0]  min_val,
    output logic [4:0]  min_idx,
    output logic        out_valid,
    output logic        busy,
    output logic        ovf
);
    // Handshake: a sample transfers on a rising edge where in_valid && in_ready;
    // in_ready is high only in IDLE, and upstream holds in_sel until that edge.
    typedef enum logic [1:0] {IDLE, SCAN, NORM} state_t;

    state_t      state_q, state_d;
    logic [3:0]  st_q [18];
    logic [3:0]  st_inc [18];
    logic [4:0]  idx_q;
    logic [3:0]  run_min_q;
    logic [4:0]  run_idx_q;
    logic [3:0]  min_val_q;
    logic [4:0]  min_idx_q;
    logic        out_valid_q;
    logic        ovf_q;
    logic        ovf_hit;
    logic        accept;
    logic [3:0]  cur;
    logic        take;

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign accept    = in_valid && in_ready;
    assign min_val   = min_val_q;
    assign min_idx   = min_idx_q;
    assign out_valid = out_valid_q;
    assign ovf       = ovf_q;

    always_comb begin
        for (int i = 0; i < 18; i++) state_flat[4*i +: 4] = st_q[i];
    end

    // Increment path; an element already at 15 either sticks or wraps.
    always_comb begin
        ovf_hit = 1'b0;
        for (int i = 0; i < 18; i++) begin
            if (in_sel[i] && (st_q[i] == 4'hF)) begin
                ovf_hit = 1'b1;
`ifdef DEM_SAT_EN
                st_inc[i] = 4'hF;
`else
                st_inc[i] = 4'h0;
`endif
            end else begin
                st_inc[i] = st_q[i] + {3'b000, in_sel[i]};
            end
        end
    end

    // Strict less-than keeps the lowest index on ties.
    assign cur  = st_q[idx_q];
    assign take = (idx_q == 5'd0) || (cur < run_min_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SCAN;
            SCAN:    if (idx_q == 5'd17) state_d = NORM;
            NORM:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= 5'd0;
            run_min_q   <= 4'hF;
            run_idx_q   <= 5'd0;
            min_val_q   <= 4'h0;
            min_idx_q   <= 5'd0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            for (int i = 0; i < 18; i++) st_q[i] <= 4'h0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        for (int i = 0; i < 18; i++) st_q[i] <= st_inc[i];
                        if (ovf_hit) ovf_q <= 1'b1;
                        idx_q     <= 5'd0;
                        run_min_q <= 4'hF;
                        run_idx_q <= 5'd0;
                    end
                end
                SCAN: begin
                    if (take) begin
                        run_min_q <= cur;
                        run_idx_q <= idx_q;
                    end
                    if (idx_q != 5'd17) idx_q <= idx_q + 5'd1;
                end
                NORM: begin
                    for (int i = 0; i < 18; i++) st_q[i] <= st_q[i] - run_min_q;
                    min_val_q   <= run_min_q;
                    min_idx_q   <= run_idx_q;
                    out_valid_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
